ascii_seq_gen: RTL

Framed ASCII sequence generator. It is the writer side of the character-stream interface that the sequence verifier (`verify`) reads. On a start request it plays one of a fixed set of ROM messages as `ascii_char`/`char_valid` strobes, paced at the UART RX character rate. Each message is framed by a leading and a trailing 0x00, which lets the verifier be driven on-chip without a UART receiver.

---
 rtl/ascii_seq_gen_pkg.sv | 46 ++++
 rtl/ascii_seq_gen_slot_timer.sv | 35 +++
 rtl/ascii_seq_gen.sv | 136 +++++++++++++
 3 files changed

// File: rtl/ascii_seq_gen_pkg.sv
// Shared types and message ROM for the framed ASCII sequence generator.
// Holds the state enum, ROM contents and small lookup helpers.
package seq_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_BODY,
        ST_TRAIL,
        ST_DONE
    } state_e;

    localparam int NUM_MSG = 3;
    localparam int MSG_MAX = 16;

    localparam logic [4:0] MSG_LEN [NUM_MSG] = '{5'd7, 5'd4, 5'd6};

    localparam logic [7:0] MSG_ROM [NUM_MSG][MSG_MAX] = '{
        '{8'h20, 8'h61, 8'h65, 8'h69, 8'h21, 8'h31, 8'h32, 8'h00,
          8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'h4F, 8'h55, 8'h2C, 8'h35, 8'h00, 8'h00, 8'h00, 8'h00,
          8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'h61, 8'h65, 8'h69, 8'h58, 8'h31, 8'h32, 8'h00, 8'h00,
          8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}
    };

    // Out-of-range selections behave as an empty message.
    function automatic logic [4:0] msg_len(input logic [1:0] sel);
        if (int'(sel) < NUM_MSG) begin
            return MSG_LEN[sel];
        end
        return 5'd0;
    endfunction

    function automatic logic [7:0] msg_byte(input logic [1:0] sel, input logic [3:0] idx);
        if (int'(sel) < NUM_MSG) begin
            return MSG_ROM[sel][idx];
        end
        return 8'h00;
    endfunction

    function automatic logic [1:0] next_msg(input logic [1:0] sel);
        return 2'((int'(sel) + 1) % NUM_MSG);
    endfunction

endpackage

// File: rtl/ascii_seq_gen_slot_timer.sv
// Character slot timer: counts 0..TR-1 while enabled, held at 0 otherwise.
// tick marks the last cycle of a slot.
module slot_timer #(
    parameter int TR = 10
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int CW = (TR > 1) ? $clog2(TR) : 1;
    localparam logic [CW-1:0] LAST = CW'(TR - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/ascii_seq_gen.sv
// Framed ASCII sequence generator: plays a ROM message between 0x00 frame bytes.
// IDLE -> LEAD -> BODY -> TRAIL -> DONE; ASCII_SEQ_GEN_LOOP_EN adds a `loop` input to chain messages.
module ascii_seq_gen
    import seq_gen_pkg::*;
#(
    parameter int UART_RX_BAUD = 20,
    parameter int freq         = 200,
    parameter int TR           = freq / UART_RX_BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] msg_sel,
`ifdef ASCII_SEQ_GEN_LOOP_EN
    input  logic       loop,
`endif
    output logic [7:0] ascii_char,
    output logic       char_valid,
    output logic       busy,
    output logic       done
);

    generate
        if (TR < 2) begin : g_tr_check
            $error("ascii_seq_gen: TR must be at least 2");
        end
    endgenerate

    state_e     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] idx_q, idx_d;
    logic       loop_done_q, loop_done_d;
    logic       tick;
    logic       timer_en;
    logic [4:0] cur_len;

    assign cur_len  = msg_len(sel_q);
    assign timer_en = (state_q == ST_LEAD) || (state_q == ST_BODY) || (state_q == ST_TRAIL);

    slot_timer #(
        .TR (TR)
    ) u_slot_timer (
        .clk_i  (clk),
        .rst_i  (rst),
        .en_i   (timer_en),
        .tick_o (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= 2'd0;
            idx_q       <= 4'd0;
            loop_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            idx_q       <= idx_d;
            loop_done_q <= loop_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        idx_d       = idx_q;
        loop_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LEAD;
                    sel_d   = msg_sel;
                end
            end
            ST_LEAD: begin
                if (tick) begin
                    idx_d   = 4'd0;
                    state_d = (cur_len == 5'd0) ? ST_TRAIL : ST_BODY;
                end
            end
            ST_BODY: begin
                if (tick) begin
                    // A 16-byte message wraps len-1 to 4'hF, which is still the last index.
                    if (idx_q == (cur_len[3:0] - 4'd1)) begin
                        state_d = ST_TRAIL;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            ST_TRAIL: begin
                if (tick) begin
                    state_d = ST_DONE;
`ifdef ASCII_SEQ_GEN_LOOP_EN
                    if (loop) begin
                        state_d     = ST_LEAD;
                        sel_d       = next_msg(sel_q);
                        loop_done_d = 1'b1;
                    end
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        ascii_char = 8'h00;
        char_valid = 1'b0;
        busy       = 1'b0;
        done       = loop_done_q;
        case (state_q)
            ST_LEAD, ST_TRAIL: begin
                busy       = 1'b1;
                char_valid = tick;
            end
            ST_BODY: begin
                busy       = 1'b1;
                char_valid = tick;
                ascii_char = msg_byte(sel_q, idx_q);
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
